ram_bank_arbiter: RTL

- Shares one ram_bank between two requesters, port 0 and port 1. Each requester issues single-word read or write commands over a req/gnt handshake.
- Grants at most one command per cycle, round-robin by default, and drives the ram_bank command pins from registers.
- Routes each returned read word back to the requester that issued it, with a per-port valid strobe.
- Sits between the two client blocks and ram_bank.

---
 rtl/ram_bank_pkg.sv | 16 +
 rtl/rr_arb2.sv | 45 ++++
 rtl/ram_bank_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ram_bank_pkg.sv
// Shared widths, command type and port tags for the ram_bank arbiter slice.
package ram_bank_pkg;

   localparam int unsigned RAM_ADDR_BIT = 3;
   localparam int unsigned RAM_DATA_BIT = 16;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   typedef struct packed {
      logic                    wr;
      logic [RAM_ADDR_BIT-1:0] addr;
      logic [RAM_DATA_BIT-1:0] wdata;
   } ram_cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant: round-robin pointer or fixed port-0 priority, synchronous reset.
module rr_arb2 #(
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   logic r_ptr;
   logic w_ptr_d;

   always_comb begin
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      w_ptr_d = r_ptr;
      if (rst_n) begin
         if (req0 && req1) begin
            // Pointer names the winner of the next contested cycle.
            if ((FIXED_PRIO != 0) || !r_ptr) begin
               gnt0    = 1'b1;
               w_ptr_d = (FIXED_PRIO != 0) ? 1'b0 : 1'b1;
            end else begin
               gnt1    = 1'b1;
               w_ptr_d = 1'b0;
            end
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr <= 1'b0;
      end else begin
         r_ptr <= w_ptr_d;
      end
   end

endmodule

// File: rtl/ram_bank_arbiter.sv
// Arbitrates two requesters onto one ram_bank: registered command pins and a
// two-stage read tag pipeline that steers returned data to its issuer.
module ram_bank_arbiter
   import ram_bank_pkg::*;
#(
   parameter int unsigned ADDR_BIT   = RAM_ADDR_BIT,
   parameter int unsigned DATA_BIT   = RAM_DATA_BIT,
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req0,
   input  logic                req1,
   input  logic                wr0,
   input  logic                wr1,
   input  logic [ADDR_BIT-1:0] addr0,
   input  logic [ADDR_BIT-1:0] addr1,
   input  logic [DATA_BIT-1:0] wdata0,
   input  logic [DATA_BIT-1:0] wdata1,
   output logic                gnt0,
   output logic                gnt1,
   output logic                rvalid0,
   output logic                rvalid1,
   output logic [DATA_BIT-1:0] rdata0,
   output logic [DATA_BIT-1:0] rdata1,
   output logic                ram_en,
   output logic                ram_we,
   output logic                ram_re,
   output logic [ADDR_BIT-1:0] ram_addr_w,
   output logic [DATA_BIT-1:0] ram_d_w,
   output logic [ADDR_BIT-1:0] ram_addr_r,
   input  logic [DATA_BIT-1:0] ram_d_r
);

   logic                w_gnt0;
   logic                w_gnt1;
   logic                w_any;
   logic                w_wr;
   logic [ADDR_BIT-1:0] w_addr;
   logic [DATA_BIT-1:0] w_wdata;

   logic                r_en;
   logic                r_we;
   logic                r_re;
   logic [ADDR_BIT-1:0] r_addr_w;
   logic [DATA_BIT-1:0] r_d_w;
   logic [ADDR_BIT-1:0] r_addr_r;
   logic                r_tag1_vld;
   logic                r_tag1_own;
   logic                r_tag2_vld;
   logic                r_tag2_own;
   logic [DATA_BIT-1:0] r_rdata0;
   logic [DATA_BIT-1:0] r_rdata1;

   rr_arb2 #(
      .FIXED_PRIO(FIXED_PRIO)
   ) u_arb (
      .clk  (clk),
      .rst_n(rst_n),
      .req0 (req0),
      .req1 (req1),
      .gnt0 (w_gnt0),
      .gnt1 (w_gnt1)
   );

   always_comb begin
      w_any   = w_gnt0 || w_gnt1;
      w_wr    = w_gnt1 ? wr1    : wr0;
      w_addr  = w_gnt1 ? addr1  : addr0;
      w_wdata = w_gnt1 ? wdata1 : wdata0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_en     <= 1'b0;
         r_we     <= 1'b0;
         r_re     <= 1'b0;
         r_addr_w <= '0;
         r_d_w    <= '0;
         r_addr_r <= '0;
      end else begin
         r_en <= w_any;
         r_we <= w_any && w_wr;
         r_re <= w_any && !w_wr;
         if (w_any && w_wr) begin
            r_addr_w <= w_addr;
            r_d_w    <= w_wdata;
         end
         if (w_any && !w_wr) begin
            r_addr_r <= w_addr;
         end
      end
   end

   // Reset clears both tag stages, so a read in flight never returns.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tag1_vld <= 1'b0;
         r_tag1_own <= PORT0;
         r_tag2_vld <= 1'b0;
         r_tag2_own <= PORT0;
         r_rdata0   <= '0;
         r_rdata1   <= '0;
      end else begin
         r_tag1_vld <= w_any && !w_wr;
         r_tag1_own <= w_gnt1 ? PORT1 : PORT0;
         r_tag2_vld <= r_tag1_vld;
         r_tag2_own <= r_tag1_own;
         if (r_tag1_vld) begin
            if (r_tag1_own == PORT1) begin
               r_rdata1 <= ram_d_r;
            end else begin
               r_rdata0 <= ram_d_r;
            end
         end
      end
   end

   assign gnt0       = w_gnt0;
   assign gnt1       = w_gnt1;
   assign rvalid0    = r_tag2_vld && (r_tag2_own == PORT0);
   assign rvalid1    = r_tag2_vld && (r_tag2_own == PORT1);
   assign rdata0     = r_rdata0;
   assign rdata1     = r_rdata1;
   assign ram_en     = r_en;
   assign ram_we     = r_we;
   assign ram_re     = r_re;
   assign ram_addr_w = r_addr_w;
   assign ram_d_w    = r_d_w;
   assign ram_addr_r = r_addr_r;

endmodule
